// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared FSM state encodings and release-mode constants for the reset sequencer.
package rst_seq_pkg;
  typedef enum logic [1:0] {ST_HOLD = 2'b00, ST_RELEASE = 2'b01, ST_RUN = 2'b10} state_e;
  localparam int MODE_SIMUL = 0;
  localparam int MODE_STAGGER = 1;
endpackage

// File: rtl/rst_ch_pulse.sv
// rst_ch_pulse: one reset channel, held by the sequencer via force_i or pulsed for HOLD_CYCLES by a retriggerable soft request.
module rst_ch_pulse #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic force_i,
  input  logic trig_i,
  output logic rst_o
);
  localparam int W = $clog2(HOLD_CYCLES + 1);
  logic [W-1:0] rem_q;
  logic rst_q;
  // rem_q counts edges still to hold after this one; reaching zero releases the channel
  always_ff @(posedge clk) begin
    if (rst || force_i) begin
      rst_q <= 1'b1;
      rem_q <= '0;
    end else if (trig_i) begin
      rst_q <= 1'b1;
      rem_q <= W'(HOLD_CYCLES - 1);
    end else begin
      rst_q <= rem_q != '0;
      rem_q <= rem_q - W'(rem_q != '0);
    end
  end
  assign rst_o = rst_q;
endmodule

// File: rtl/rst_seq_gen.sv
// rst_seq_gen: power-on reset sequencer releasing NUM_CH channels simultaneously or staggered, then serving soft-reset pulses.
module rst_seq_gen
  import rst_seq_pkg::*;
#(
  parameter int NUM_CH      = 7,
  parameter int HOLD_CYCLES = 4,
  parameter int STAGGER     = 2,
  parameter int SEQ_MODE    = 1
) (
  input  logic              tb_clk,
  input  logic              tb_rst,
  input  logic [1:NUM_CH]   sw_rst_req,
  output logic [1:NUM_CH]   rst_out,
  output logic              seq_done,
  output logic [1:0]        seq_state
);
  localparam int LAST = STAGGER * (NUM_CH - 1);
  localparam int CMAX = HOLD_CYCLES > LAST ? HOLD_CYCLES : LAST;
  localparam int CW = $clog2(CMAX + 1);
  // a single channel has nothing to stagger, so it takes the simultaneous path
  localparam bit DIRECT = (SEQ_MODE == MODE_SIMUL) || (NUM_CH == 1);
  state_e state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic done_q, hold_end;
  logic [1:NUM_CH] rel_d;
  assign cnt_d = cnt_q == CW'(CMAX) ? cnt_q : cnt_q + 1'b1;
  assign hold_end = state_q == ST_HOLD && cnt_q == CW'(HOLD_CYCLES);
  always_ff @(posedge tb_clk) begin
    if (tb_rst) begin
      state_q <= ST_HOLD;
      cnt_q <= '0;
      done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (hold_end) begin
            state_q <= DIRECT ? ST_RUN : ST_RELEASE;
            cnt_q <= '0;
            done_q <= DIRECT;
          end else cnt_q <= cnt_d;
        end
        ST_RELEASE: begin
          cnt_q <= cnt_d;
          if (cnt_d == CW'(LAST)) begin
            state_q <= ST_RUN;
            done_q <= 1'b1;
          end
        end
        ST_RUN: done_q <= 1'b1;
        default: begin
          state_q <= ST_HOLD;
          cnt_q <= '0;
          done_q <= 1'b0;
        end
      endcase
    end
  end
  // rel_d marks channels whose sequencer hold is lifted on this edge
  for (genvar i = 1; i <= NUM_CH; i++) begin : g_ch
    assign rel_d[i] = state_q == ST_RUN || (hold_end && (i == 1 || DIRECT)) ||
                      (state_q == ST_RELEASE && int'(cnt_d) >= STAGGER * (i - 1));
    rst_ch_pulse #(.HOLD_CYCLES(HOLD_CYCLES)) u_ch (
      .clk(tb_clk),
      .rst(tb_rst),
      .force_i(~rel_d[i]),
      .trig_i(state_q == ST_RUN && sw_rst_req[i]),
      .rst_o(rst_out[i])
    );
  end
  assign seq_done = done_q;
  assign seq_state = state_q;
endmodule

// File: tb/tb_rst_seq_gen.sv
// tb_rst_seq_gen: scoreboard bench for staggered and simultaneous reset sequencers against a timeline model.
module tb_rst_seq_gen;
  localparam int N = 7, H = 4, S = 2;
  typedef struct packed {logic [1:N] r; logic d; logic [1:0] s;} obs_t;
  logic tb_clk = 0, tb_rst = 1;
  logic [1:N] sw = '0, ro1, ro0;
  logic dn1, dn0;
  logic [1:0] st1, st0;
  obs_t q[2][$];
  int n = -1, end_t[2][1:N];
  int checks = 0, errors = 0;
  always #5 tb_clk = ~tb_clk;

  rst_seq_gen #(.NUM_CH(N), .HOLD_CYCLES(H), .STAGGER(S), .SEQ_MODE(1)) u_dut (
    .tb_clk(tb_clk), .tb_rst(tb_rst), .sw_rst_req(sw), .rst_out(ro1), .seq_done(dn1), .seq_state(st1));
  rst_seq_gen #(.NUM_CH(N), .HOLD_CYCLES(H), .STAGGER(S), .SEQ_MODE(0)) u_dut0 (
    .tb_clk(tb_clk), .tb_rst(tb_rst), .sw_rst_req(sw), .rst_out(ro0), .seq_done(dn0), .seq_state(st0));

  function automatic int rel_t(int m, int i);
    return m == 1 ? H + S * (i - 1) : H;
  endfunction

  // model: n is the index of the edge just taken since tb_rst fell
  always @(posedge tb_clk) begin
    obs_t e;
    int dt;
    if (tb_rst) begin
      n = -1;
      for (int m = 0; m < 2; m++) begin
        for (int i = 1; i <= N; i++) end_t[m][i] = 0;
        q[m].push_back('{r: '1, d: 1'b0, s: 2'd0});
      end
    end else begin
      n++;
      for (int m = 0; m < 2; m++) begin
        dt = rel_t(m, N);
        for (int i = 1; i <= N; i++) begin
          if (n > dt && sw[i]) end_t[m][i] = n + H;
          e.r[i] = (n < rel_t(m, i)) || (n < end_t[m][i]);
        end
        e.d = n >= dt;
        e.s = n < H ? 2'd0 : (n < dt ? 2'd1 : 2'd2);
        q[m].push_back(e);
      end
    end
  end

  always @(posedge tb_clk) begin
    obs_t a, x;
    #1;
    for (int m = 0; m < 2; m++) begin
      a = m == 1 ? '{r: ro1, d: dn1, s: st1} : '{r: ro0, d: dn0, s: st0};
      checks++;
      if (q[m].size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty mode=%0d t=%0t", m, $time);
      end else begin
        x = q[m].pop_front();
        if (a.r !== x.r) begin
          errors++;
          $display("FAIL rst_out mode=%0d t=%0t got %b exp %b", m, $time, a.r, x.r);
        end
        checks++;
        if (a.d !== x.d) begin
          errors++;
          $display("FAIL seq_done mode=%0d t=%0t got %b exp %b", m, $time, a.d, x.d);
        end
        checks++;
        if (a.s !== x.s) begin
          errors++;
          $display("FAIL seq_state mode=%0d t=%0t got %b exp %b", m, $time, a.s, x.s);
        end
      end
    end
  end

  task automatic cyc(input logic r, input logic [1:N] s);
    tb_rst = r;
    sw = s;
    @(negedge tb_clk);
  endtask

  initial begin
    logic [1:N] s;
    repeat (4) cyc(1'b1, '0);
    for (int k = 0; k <= 50; k++) begin
      s = '0;
      if (k < 6) s[1] = 1'b1;
      if (k == 30) s[3] = 1'b1;
      if (k == 40 || k == 42) s[5] = 1'b1;
      if (k == 40) s[2] = 1'b1;
      cyc(1'b0, s);
    end
    repeat (2) cyc(1'b1, '0);
    for (int k = 0; k < 10; k++) cyc(1'b0, '0);
    cyc(1'b1, '0);
    for (int k = 0; k < 25; k++) cyc(1'b0, '0);
    for (int k = 0; k < 2000; k++) begin
      for (int i = 1; i <= N; i++) s[i] = $urandom_range(0, 7) == 0;
      cyc($urandom_range(0, 149) == 0, s);
    end
    repeat (2) @(negedge tb_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rst_seq_gen.md
RST_SEQ_GEN -- requirements
Module: rst_seq_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 7, number of reset output channels (NUM_CH >= 1).
REQ-002 SHALL have parameter HOLD_CYCLES, default 4, cycles all channels stay asserted after input reset release (>= 1).
REQ-003 SHALL have parameter STAGGER, default 2, cycles between successive channel releases in staggered mode (>= 1).
REQ-004 SHALL have parameter SEQ_MODE, default 1: 0 = simultaneous release, 1 = staggered release.
REQ-005 SHALL have port tb_clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port tb_rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port sw_rst_req  input  [1:NUM_CH]  per-channel soft-reset request, sampled each edge.
REQ-008 SHALL have port rst_out  output  [1:NUM_CH]  active-high channel resets, registered.
REQ-009 SHALL have port seq_done  output  1  power-on sequence complete, registered.
REQ-010 SHALL have port seq_state  output  2  current FSM state encoding, for debug.

Function
REQ-011 SHALL implement FSM states HOLD (00), RELEASE (01), RUN (10); 11 unused, recovers to HOLD.
REQ-012 SHALL, in HOLD, keep all rst_out = 1 and count edges with tb_rst low; at count HOLD_CYCLES, SHALL clear rst_out[1] (mode 1) or all rst_out (mode 0).
REQ-013 SHALL, in mode 1, clear rst_out[i] exactly STAGGER*(i-1) edges after rst_out[1] clears, for i = 2..NUM_CH, while in RELEASE.
REQ-014 SHALL set seq_done = 1 and enter RUN on the same edge rst_out[NUM_CH] clears; mode 0 goes HOLD -> RUN directly.
REQ-015 SHALL, with NUM_CH = 1, behave identically in both modes.
REQ-016 SHALL, in RUN, on sw_rst_req[i] sampled high at edge e, drive rst_out[i] = 1 from edge e and clear it at edge e + HOLD_CYCLES.
REQ-017 SHALL restart the channel-i soft-reset count when sw_rst_req[i] is sampled high while that pulse is still active (retrigger, no accumulation).
REQ-018 SHALL handle soft requests on multiple channels independently and concurrently; unrequested channels unaffected.
REQ-019 SHALL ignore sw_rst_req in HOLD and RELEASE.
REQ-020 SHALL keep seq_done = 1 during soft-reset pulses in RUN.
REQ-021 SHALL size all counters to hold max(HOLD_CYCLES, STAGGER*(NUM_CH-1)) without wrap; counters saturate, never wrap.

Reset
REQ-022 SHALL, on any edge with tb_rst = 1, set rst_out = all ones, seq_done = 0, state = HOLD, and clear all counters and soft-reset pulses.
REQ-023 SHALL apply REQ-022 when tb_rst asserts mid-RELEASE or mid-soft-pulse; sequence restarts from HOLD count 0 when tb_rst falls.
REQ-024 SHALL give tb_rst priority over sw_rst_req sampled on the same edge.

Structure
REQ-025 SHALL place state encodings and the mode constants in shared package rst_seq_pkg.
REQ-026 SHALL instantiate NUM_CH copies of sub-module rst_ch_pulse (per-channel retriggerable HOLD_CYCLES pulse counter with sequencer force input).
REQ-027 SHALL derive counter widths locally via $clog2 from parameters.

Verification (defaults NUM_CH=7, HOLD_CYCLES=4, STAGGER=2; edge 0 = first edge with tb_rst low)
REQ-028 SHALL cover: tb_rst high 4 edges then low -> rst_out[1] clears at edge 4, rst_out[7] at edge 16, seq_done = 1 at edge 16, seq_state = 10.
REQ-029 SHALL cover: SEQ_MODE=0 -> all rst_out clear and seq_done sets together at edge 4.
REQ-030 SHALL cover: in RUN, sw_rst_req[3] one-cycle pulse at edge 30 -> rst_out[3] high edges 30..33, low at 34, other channels 0.
REQ-031 SHALL cover: sw_rst_req[5] at edges 40 and 42 -> rst_out[5] low at edge 46 (retrigger); sw_rst_req[2] at 40 concurrently -> rst_out[2] low at 44.
REQ-032 SHALL cover: tb_rst high at edge 10 (mid-RELEASE) -> rst_out = 7'h7F, seq_done = 0 next edge; release sequence repeats with same timing.
REQ-033 SHALL cover: sw_rst_req[1] high during HOLD -> no effect on release timing of REQ-028.
